// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the 4-digit multiplexed 7-segment
//               driver. Contents: active-low segment encodings (g..a), digit
//               slot indices, conversion FSM state encoding and a digit
//               encoder helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Digit slot indices (also the anode bit position)
    localparam logic [1:0] DIG_R1  = 2'd0;
    localparam logic [1:0] DIG_R10 = 2'd1;
    localparam logic [1:0] DIG_L1  = 2'd2;
    localparam logic [1:0] DIG_L10 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_L  = 3'd1,
        ST_SHIFT_L = 3'd2,
        ST_LOAD_R  = 3'd3,
        ST_SHIFT_R = 3'd4,
        ST_COMMIT  = 3'd5
    } state_t;

    function automatic logic [6:0] seg_enc(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_bin2bcd8.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd8
// Description : Sequential 8-bit binary to 2-digit BCD converter
//               (shift-add-3). One add-3-then-shift step per clock, 8 steps.
// Ports       : clk, rst (async, active-high)
//               start - load bin and begin conversion
//               bin   - 8-bit binary operand
//               bcd   - {tens, ones}; valid once done has been seen
//               done  - high during the cycle of the final shift step
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic [7:0] bcd,
    output logic       done
);

    // {tens, ones, binary}. The hundreds digit is not kept: the lower two
    // BCD digits of double-dabble do not depend on it, so bcd = value mod 100.
    logic [15:0] sr_q, sr_d, adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    always_comb begin
        adj = sr_q;
        if (sr_q[11:8] >= 4'd5)  adj[11:8]  = sr_q[11:8]  + 4'd3;
        if (sr_q[15:12] >= 4'd5) adj[15:12] = sr_q[15:12] + 4'd3;

        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done   = 1'b0;
        if (start) begin
            sr_d   = {8'd0, bin};
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = adj << 1;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign bcd = sr_q[15:8];

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan
// Description : 4-digit multiplexed common-anode 7-segment driver for two
//               8-bit countdown values. Left road on digits 3:2, right road
//               on digits 1:0. BCD conversion runs once per refresh frame and
//               the displayed digits are swapped in a single cycle.
//               Build option: SEG7_LZ_BLANK_EN blanks a leading-zero tens
//               digit for values 0..9.
// Ports       : clk, rst (async, active-high)
//               lcnt, rcnt     - binary countdown values
//               lflash, rflash - 1 = channel lit, 0 = channel blanked (live)
//               an             - active-low digit enables, an[0] = right ones
//               seg            - active-low segments, seg[0] = a
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcnt,
    input  logic [7:0] rcnt,
    input  logic       lflash,
    input  logic       rflash,
    output logic [3:0] an,
    output logic [6:0] seg
);

    logic [SCAN_DIV_W-1:0] div_q, div_d;
    logic [1:0]            idx_q, idx_d;
    state_t                state_q, state_d;
    logic [7:0]            lhold_q, lhold_d, rhold_q, rhold_d;
    logic [7:0]            lbcd_q, lbcd_d;
    logic [7:0]            disp_l_q, disp_l_d, disp_r_q, disp_r_d;
    logic                  lover_q, lover_d, rover_q, rover_d;
    logic                  valid_q, valid_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  conv_start, conv_done;
    logic [7:0]            conv_bin, conv_bcd;
    logic                  frame_start, dead;
    logic                  is_left, over, lit, lz_blank;
    logic [3:0]            nib;

    bin2bcd8 u_bin2bcd8 (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Refresh divider and digit index
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == {SCAN_DIV_W{1'b1}}) idx_d = idx_q + 2'd1;
    end

    assign dead        = (div_q == '0);
    assign frame_start = dead && (idx_q == DIG_R1);

    // Conversion sequencer: one converter shared by both channels
    always_comb begin
        state_d    = state_q;
        lhold_d    = lhold_q;
        rhold_d    = rhold_q;
        lbcd_d     = lbcd_q;
        disp_l_d   = disp_l_q;
        disp_r_d   = disp_r_q;
        lover_d    = lover_q;
        rover_d    = rover_q;
        valid_d    = valid_q;
        conv_start = 1'b0;
        conv_bin   = lhold_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_LOAD_L;
            end
            ST_LOAD_L: begin
                // Snapshot both inputs together so the frame is coherent
                lhold_d    = lcnt;
                rhold_d    = rcnt;
                conv_start = 1'b1;
                conv_bin   = lcnt;
                state_d    = ST_SHIFT_L;
            end
            ST_SHIFT_L: begin
                if (conv_done) state_d = ST_LOAD_R;
            end
            ST_LOAD_R: begin
                lbcd_d     = conv_bcd;
                conv_start = 1'b1;
                conv_bin   = rhold_q;
                state_d    = ST_SHIFT_R;
            end
            ST_SHIFT_R: begin
                if (conv_done) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                disp_l_d = lbcd_q;
                disp_r_d = conv_bcd;
                lover_d  = (lhold_q > 8'd99);
                rover_d  = (rhold_q > 8'd99);
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Digit select and output encoding
    always_comb begin
        is_left = 1'b0;
        nib     = disp_r_q[3:0];
        case (idx_q)
            DIG_R1:  nib = disp_r_q[3:0];
            DIG_R10: nib = disp_r_q[7:4];
            DIG_L1:  begin is_left = 1'b1; nib = disp_l_q[3:0]; end
            DIG_L10: begin is_left = 1'b1; nib = disp_l_q[7:4]; end
            default: nib = disp_r_q[3:0];
        endcase
        over = is_left ? lover_q : rover_q;
        lit  = is_left ? lflash  : rflash;
`ifdef SEG7_LZ_BLANK_EN
        lz_blank = idx_q[0] && !over && (nib == 4'd0);
`else
        lz_blank = 1'b0;
`endif
        if (!valid_q)  seg_d = SEG_OFF;
        else if (over) seg_d = SEG_DASH;
        else           seg_d = seg_enc(nib);

        an_d = 4'hF;
        if (valid_q && !dead && lit && !lz_blank) an_d = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            idx_q    <= '0;
            state_q  <= ST_IDLE;
            lhold_q  <= '0;
            rhold_q  <= '0;
            lbcd_q   <= '0;
            disp_l_q <= '0;
            disp_r_q <= '0;
            lover_q  <= 1'b0;
            rover_q  <= 1'b0;
            valid_q  <= 1'b0;
            an_q     <= 4'hF;
            seg_q    <= SEG_OFF;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            lhold_q  <= lhold_d;
            rhold_q  <= rhold_d;
            lbcd_q   <= lbcd_d;
            disp_l_q <= disp_l_d;
            disp_r_q <= disp_r_d;
            lover_q  <= lover_d;
            rover_q  <= rover_d;
            valid_q  <= valid_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan
// Description : Self-checking bench for seg7_scan with SCAN_DIV_W = 6
//               (64 clocks per slot, 256 per frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

    localparam int W     = 6;
    localparam int SLOT  = 64;
    localparam int FRAME = 256;
`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] l;
        logic [7:0] r;
        logic       lf;
        logic       rf;
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] lcnt = 8'd0;
    logic [7:0] rcnt = 8'd0;
    logic       lflash = 1'b1;
    logic       rflash = 1'b1;
    logic [3:0] an;
    logic [6:0] seg;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    vec_t vecs[$];

    seg7_scan #(.SCAN_DIV_W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .lcnt   (lcnt),
        .rcnt   (rcnt),
        .lflash (lflash),
        .rflash (rflash),
        .an     (an),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc < k) step();
    endtask

    task automatic next_frame();
        goto((cyc / FRAME + 1) * FRAME);
    endtask

    task automatic at_slot(input int s, input int off);
        goto((cyc / FRAME) * FRAME + s * SLOT + off);
    endtask

    task automatic check(input string nm, input logic [3:0] ea, input logic [6:0] es);
        n_chk++;
        if (an !== ea || seg !== es) begin
            n_fail++;
            $display("FAIL %s: got an=%h seg=%h, expected an=%h seg=%h (cyc %0d)",
                     nm, an, seg, ea, es, cyc);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic void add(input string n, input logic [7:0] l, input logic [7:0] r,
                                input logic lf, input logic rf, input int s,
                                input logic [3:0] a, input logic [6:0] sg);
        vec_t v;
        v.name = n; v.l = l; v.r = r; v.lf = lf; v.rf = rf;
        v.slot = s; v.an = a; v.seg = sg;
        vecs.push_back(v);
    endfunction

    initial begin
        // Encodings: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10, dash=3F
        add("v22_s3",     8'd22,  8'd7,   1, 1, 3, 4'h7, 7'h24);
        add("v22_s2",     8'd22,  8'd7,   1, 1, 2, 4'hB, 7'h24);
        add("v7_s1",      8'd22,  8'd7,   1, 1, 1, LZ ? 4'hF : 4'hD, 7'h40);
        add("v7_s0",      8'd22,  8'd7,   1, 1, 0, 4'hE, 7'h78);
        add("v150_s3",    8'd150, 8'd0,   1, 1, 3, 4'h7, 7'h3F);
        add("v150_s2",    8'd150, 8'd0,   1, 1, 2, 4'hB, 7'h3F);
        add("v0_s1",      8'd150, 8'd0,   1, 1, 1, LZ ? 4'hF : 4'hD, 7'h40);
        add("v0_s0",      8'd150, 8'd0,   1, 1, 0, 4'hE, 7'h40);
        add("lflash0_s3", 8'd22,  8'd7,   0, 1, 3, 4'hF, 7'h24);
        add("lflash0_s0", 8'd22,  8'd7,   0, 1, 0, 4'hE, 7'h78);
        add("rflash0_s1", 8'd22,  8'd7,   1, 0, 1, 4'hF, 7'h40);
        add("rflash0_s2", 8'd22,  8'd7,   1, 0, 2, 4'hB, 7'h24);
        add("v99_s3",     8'd99,  8'd255, 1, 1, 3, 4'h7, 7'h10);
        add("v255_s0",    8'd99,  8'd255, 1, 1, 0, 4'hE, 7'h3F);
        add("v100_s2",    8'd100, 8'd45,  1, 1, 2, 4'hB, 7'h3F);
        add("v45_s1",     8'd100, 8'd45,  1, 1, 1, 4'hD, 7'h19);
        add("v45_s0",     8'd100, 8'd45,  1, 1, 0, 4'hE, 7'h12);
        add("v38_s3",     8'd38,  8'd61,  1, 1, 3, 4'h7, 7'h30);
        add("v38_s2",     8'd38,  8'd61,  1, 1, 2, 4'hB, 7'h00);
        add("v61_s1",     8'd38,  8'd61,  1, 1, 1, 4'hD, 7'h02);
        add("v0l_s3",     8'd0,   8'd9,   1, 1, 3, LZ ? 4'hF : 4'h7, 7'h40);
        add("v9_s0",      8'd0,   8'd9,   1, 1, 0, 4'hE, 7'h10);

        // Reset and first conversion
        repeat (3) step();
        check("reset_hold", 4'hF, 7'h7F);
        release_rst();
        goto(19);
        check("pre_commit", 4'hF, 7'h7F);
        goto(20);
        check("commit_cycle", 4'hF, 7'h7F);
        goto(21);
        check("first_lit", 4'hE, 7'h40);
        goto(65);
        check("dead_time", 4'hF, 7'h40);
        goto(66);
        check("after_dead", LZ ? 4'hF : 4'hD, 7'h40);

        // Table-driven vectors: inputs apply from the next frame's snapshot
        foreach (vecs[i]) begin
            lcnt   = vecs[i].l;
            rcnt   = vecs[i].r;
            lflash = vecs[i].lf;
            rflash = vecs[i].rf;
            next_frame();
            at_slot(vecs[i].slot, 32);
            check(vecs[i].name, vecs[i].an, vecs[i].seg);
        end

        // Live flash toggling follows within one clock
        lcnt = 8'd22; rcnt = 8'd7; lflash = 1'b1; rflash = 1'b1;
        next_frame();
        at_slot(2, 10);
        check("flash_on_s2", 4'hB, 7'h24);
        lflash = 1'b0;
        step();
        check("flash_off_s2", 4'hF, 7'h24);
        at_slot(3, 10);
        lflash = 1'b1;
        step();
        check("flash_on_s3", 4'h7, 7'h24);
        lflash = 1'b0;
        step();
        check("flash_off_s3", 4'hF, 7'h24);
        lflash = 1'b1;

        // Mid-frame input change is held off until the next commit
        next_frame();
        at_slot(2, 10);
        lcnt = 8'd21;
        at_slot(2, 40);
        check("midframe_s2", 4'hB, 7'h24);
        at_slot(3, 32);
        check("midframe_s3", 4'h7, 7'h24);
        next_frame();
        at_slot(2, 32);
        check("newframe_s2", 4'hB, 7'h79);
        at_slot(3, 32);
        check("newframe_s3", 4'h7, 7'h24);

        // Asynchronous reset in the middle of the right-channel shift
        lcnt = 8'd38; rcnt = 8'd61;
        next_frame();
        at_slot(0, 14);
        rst = 1'b1;
        #1;
        check("async_rst", 4'hF, 7'h7F);
        release_rst();
        goto(19);
        check("rerun_pre_commit", 4'hF, 7'h7F);
        at_slot(0, 32);
        check("rerun_s0", 4'hE, 7'h79);
        at_slot(1, 32);
        check("rerun_s1", 4'hD, 7'h02);
        at_slot(3, 32);
        check("rerun_s3", 4'h7, 7'h30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
